// File: rtl/tx_burst_seq.sv
// Transmit burst sequencer: keys the PA, streams DAC playback addresses 0..n-1,
// then holds the PA for a post-roll before returning to IDLE with a done pulse.
module tx_burst_seq #(
    parameter int ADDR_W  = 14,
    parameter int PA_LEAD = 16,
    parameter int PA_LAG  = 8,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [ADDR_W-1:0] txsmps,
    output logic [ADDR_W-1:0] tx_addr,
    output logic              tx_valid,
    output logic              pa_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  missed_trig
);

    typedef enum logic [1:0] {IDLE, LEAD, PLAY, LAG} state_t;

    localparam int TMR_W = 8;
    localparam logic [TMR_W-1:0] LEAD_LOAD = TMR_W'(PA_LEAD - 1);
    localparam logic [TMR_W-1:0] LAG_LOAD  = TMR_W'(PA_LAG - 1);

    state_t             state_q, state_d;
    logic               trig_q;
    logic [ADDR_W-1:0]  n_q, n_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               valid_q, valid_d;
    logic               pa_q, pa_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   missed_q, missed_d;
    logic               trig_edge;

    assign trig_edge = trig & ~trig_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            trig_q   <= 1'b0;
            n_q      <= '0;
            tmr_q    <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            pa_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            missed_q <= '0;
        end else begin
            state_q  <= state_d;
            trig_q   <= trig;
            n_q      <= n_d;
            tmr_q    <= tmr_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            pa_q     <= pa_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            missed_q <= missed_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        tmr_d    = tmr_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        pa_d     = pa_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        missed_d = missed_q;

        unique case (state_q)
            IDLE: begin
                if (trig_edge) begin
                    state_d = LEAD;
                    n_d     = txsmps;
                    tmr_d   = LEAD_LOAD;
                    pa_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            LEAD: begin
                if (tmr_q == '0) begin
                    if (n_q != '0) begin
                        state_d = PLAY;
                        addr_d  = '0;
                        valid_d = 1'b1;
                    end else begin
                        state_d = LAG;
                        tmr_d   = LAG_LOAD;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            PLAY: begin
                if (addr_q == n_q - ADDR_W'(1)) begin
                    state_d = LAG;
                    addr_d  = '0;
                    valid_d = 1'b0;
                    tmr_d   = LAG_LOAD;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            LAG: begin
                if (tmr_q == '0) begin
                    state_d = IDLE;
                    pa_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                valid_d = 1'b0;
                pa_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        // Edges arriving while a burst runs are dropped but counted, saturating.
        if (trig_edge && state_q != IDLE && missed_q != '1)
            missed_d = missed_q + CNT_W'(1);
    end

    assign tx_addr     = addr_q;
    assign tx_valid    = valid_q;
    assign pa_en       = pa_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign missed_trig = missed_q;

endmodule

// File: tb/tb_tx_burst_seq.sv
// Randomized scoreboard bench for tx_burst_seq: a cycle-indexed burst model
// predicts accepted bursts, sample addresses and missed triggers.
module tb_tx_burst_seq;

    localparam int ADDR_W  = 14;
    localparam int PA_LEAD = 16;
    localparam int PA_LAG  = 8;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              trig = 1'b0;
    logic [ADDR_W-1:0] txsmps = '0;
    logic [ADDR_W-1:0] tx_addr, s_tx_addr;
    logic              tx_valid, s_tx_valid;
    logic              pa_en, s_pa_en;
    logic              busy, s_busy;
    logic              done, s_done;
    logic [CNT_W-1:0]  missed_trig;
    logic [1:0]        s_missed_trig;

    always #5 clk = ~clk;

    tx_burst_seq #(.ADDR_W(ADDR_W), .PA_LEAD(PA_LEAD), .PA_LAG(PA_LAG), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .trig(trig), .txsmps(txsmps),
        .tx_addr(tx_addr), .tx_valid(tx_valid), .pa_en(pa_en),
        .busy(busy), .done(done), .missed_trig(missed_trig)
    );

    // Same stimulus into a 2-bit missed counter to exercise saturation.
    tx_burst_seq #(.ADDR_W(ADDR_W), .PA_LEAD(PA_LEAD), .PA_LAG(PA_LAG), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .trig(trig), .txsmps(txsmps),
        .tx_addr(s_tx_addr), .tx_valid(s_tx_valid), .pa_en(s_pa_en),
        .busy(s_busy), .done(s_done), .missed_trig(s_missed_trig)
    );

    typedef struct {
        int n;
        bit gap1;
    } burst_t;

    burst_t burst_q[$];
    int     exp_addr_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     busy_until = -1000;
    int     model_missed = 0;
    logic   prev_t = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle; the model decides acceptance purely from burst timing.
    task automatic step(input logic t, input int s);
        burst_t b;
        @(posedge clk);
        #1;
        trig   = t;
        txsmps = ADDR_W'(s);
        cyc++;
        if (t && !prev_t) begin
            if (cyc > busy_until) begin
                b.n  = s;
                b.gap1 = (cyc == busy_until + 1);
                busy_until = cyc + PA_LEAD + s + PA_LAG;
                for (int i = 0; i < s; i++) exp_addr_q.push_back(i);
                burst_q.push_back(b);
            end else begin
                model_missed++;
            end
        end
        prev_t = t;
    endtask

    task automatic model_reset();
        exp_addr_q.delete();
        burst_q.delete();
        busy_until   = -1000;
        model_missed = 0;
        prev_t       = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (cyc <= busy_until + 2 && g < 3000) begin
            step(1'b0, int'($urandom_range(0, 200)));
            g++;
        end
        check("drain_bound", 32'(g < 3000), 32'd1);
    endtask

    task automatic check_missed(input string name);
        check(name, 32'(missed_trig), 32'(model_missed));
        check({name, "_sat"}, 32'(s_missed_trig), 32'((model_missed > 3) ? 3 : model_missed));
    endtask

    // Monitor: pops expected addresses and burst records as the DUT presents them.
    logic prev_pa = 1'b0;
    int   pa_cycles = 0, lead_cycles = 0, valid_cnt = 0, low_run = 0;
    bit   seen_valid = 1'b0;

    always @(negedge clk) begin
        burst_t b;
        if (rst) begin
            prev_pa = 1'b0;
            pa_cycles = 0; lead_cycles = 0; valid_cnt = 0; low_run = 0;
            seen_valid = 1'b0;
        end else begin
            check("valid_implies_pa", 32'(!tx_valid || pa_en), 32'd1);
            if (!tx_valid) check("addr_zero_when_invalid", 32'(tx_addr), 32'd0);
            check("busy_tracks_pa", 32'(busy), 32'(pa_en));
            check("done_pulse", 32'(done), 32'(prev_pa && !pa_en));
            check("small_pa", 32'(s_pa_en), 32'(pa_en));
            check("small_addr", 32'({s_tx_valid, s_tx_addr}), 32'({tx_valid, tx_addr}));
            check("small_flags", 32'({s_busy, s_done}), 32'({busy, done}));

            if (pa_en && !prev_pa) begin
                if (burst_q.size() == 0)
                    check("unexpected_burst", 32'd1, 32'd0);
                else if (burst_q[0].gap1)
                    check("back_to_back_gap", 32'(low_run), 32'd1);
                pa_cycles = 0; lead_cycles = 0; valid_cnt = 0; seen_valid = 1'b0;
            end

            if (tx_valid) begin
                valid_cnt++;
                if (exp_addr_q.size() == 0)
                    check("unexpected_sample", 32'(tx_addr), 32'hFFFF_FFFF);
                else
                    check("tx_addr", 32'(tx_addr), 32'(exp_addr_q.pop_front()));
            end

            if (pa_en) begin
                pa_cycles++;
                if (tx_valid) seen_valid = 1'b1;
                else if (!seen_valid) lead_cycles++;
            end

            if (!pa_en && prev_pa) begin
                if (burst_q.size() == 0) begin
                    check("burst_end_without_record", 32'd1, 32'd0);
                end else begin
                    b = burst_q.pop_front();
                    check("pa_len", 32'(pa_cycles), 32'(PA_LEAD + b.n + PA_LAG));
                    check("lead_len", 32'(lead_cycles), 32'((b.n != 0) ? PA_LEAD : PA_LEAD + PA_LAG));
                    check("sample_count", 32'(valid_cnt), 32'(b.n));
                end
            end

            low_run = pa_en ? 0 : low_run + 1;
            prev_pa = pa_en;
        end
    end

    initial begin
        int t0;
        int g;

        // Reset then idle.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) step(1'b0, int'($urandom_range(0, 200)));
        check("idle_addr", 32'(tx_addr), 32'd0);
        check("idle_valid", 32'(tx_valid), 32'd0);
        check("idle_pa", 32'(pa_en), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check_missed("idle_missed");

        // Nominal 100-sample burst.
        step(1'b1, 100);
        step(1'b0, 100);
        check("nominal_pa_first", 32'(pa_en), 32'd1);
        check("nominal_busy_first", 32'(busy), 32'd1);
        drain();

        // Zero-length burst.
        step(1'b1, 0);
        drain();

        // Held trigger plus three extra edges during PLAY.
        step(1'b1, 100);
        t0 = cyc;
        repeat (49) step(1'b1, int'($urandom_range(0, 200)));
        while (cyc < t0 + 59) step(1'b0, 7);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 9);
            repeat (9) step(1'b0, 9);
        end
        drain();
        check_missed("missed_after_3");

        // Five more edges: wide counter keeps counting, 2-bit one saturates.
        step(1'b1, 60);
        t0 = cyc;
        while (cyc < t0 + 19) step(1'b0, 60);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 3);
            repeat (4) step(1'b0, 3);
        end
        drain();
        check_missed("missed_after_8");

        // Back-to-back: edge on the done cycle, txsmps changed mid-PLAY.
        step(1'b1, 100);
        t0 = cyc;
        while (cyc < busy_until) step(1'b0, (cyc > t0 + 40) ? 5 : 100);
        step(1'b1, 5);
        step(1'b0, 5);
        check("b2b_pa_restart", 32'(pa_en), 32'd1);
        drain();
        check_missed("missed_after_b2b");

        // Randomized triggers and counts.
        repeat (1500) step(logic'($urandom_range(0, 9) == 0), int'($urandom_range(0, 40)));
        step(1'b0, 0);
        drain();
        check_missed("missed_after_random");

        // Asynchronous reset in the middle of PLAY.
        step(1'b1, 100);
        g = 0;
        while (!(tx_valid && tx_addr == ADDR_W'(40)) && g < 200) begin
            step(1'b0, 100);
            g++;
        end
        check("wait_addr40_bound", 32'(g < 200), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pa", 32'(pa_en), 32'd0);
        check("async_rst_valid", 32'(tx_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_addr", 32'(tx_addr), 32'd0);
        trig = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_missed("missed_after_rst");
        step(1'b1, 7);
        drain();

        check("leftover_samples", 32'(exp_addr_q.size()), 32'd0);
        check("leftover_bursts", 32'(burst_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
